// File: rtl/half_duplex_uart_responder.sv
// Single-wire half-duplex 8N1 UART endpoint with RX and TX FIFOs.
// The pin is driven only while a TX frame is on the line and released otherwise.
// TX waits for a run of idle line time before it starts, and RX has priority on the shared line.
// Optional build macro HD_RESP_ECHO_CHECK_EN adds echo readback with collision detection.

module hd_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign rdata   = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

module half_duplex_uart_responder #(
    parameter int CLK_FREQ_HZ     = 72_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16,
    parameter int TURNAROUND_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        serial,
    input  logic       enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_frame_error,
    output logic       rx_overflow,
    output logic       collision,
    output logic       busy
);
    localparam int CPB          = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF         = CPB / 2;
    localparam int GUARD_CYCLES = TURNAROUND_BITS * CPB;
    localparam int CNT_MAX      = (GUARD_CYCLES > CPB) ? GUARD_CYCLES : CPB;
    localparam int CW           = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CPB_LAST   = cnt_t'(CPB - 1);
    localparam cnt_t HALF_LAST  = cnt_t'(HALF - 1);
    localparam cnt_t GUARD_LAST = cnt_t'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_GUARD, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Line synchroniser and edge history.
    logic sync0;
    logic line_s;
    logic line_prev;

    // RX datapath.
    rx_state_t  rx_state;
    rx_state_t  rx_state_next;
    cnt_t       rx_cnt;
    cnt_t       rx_cnt_next;
    logic [2:0] rx_bit;
    logic [2:0] rx_bit_next;
    logic [7:0] rx_shift;
    logic [7:0] rx_shift_next;
    logic       rx_push_q;
    logic       rx_push_next;
    logic       rx_ferr_q;
    logic       rx_ferr_next;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_pop;

    // TX datapath.
    tx_state_t  tx_state;
    tx_state_t  tx_state_next;
    cnt_t       tx_cnt;
    cnt_t       tx_cnt_next;
    logic [2:0] tx_bit;
    logic [2:0] tx_bit_next;
    logic [7:0] tx_shift;
    logic [7:0] tx_shift_next;
    logic       tx_pop;
    logic       tx_push;
    logic       tx_empty;
    logic       tx_full;
    logic [7:0] tx_head;
    logic       tx_driving;
    logic       tx_out;

    assign tx_driving = (tx_state == TX_START) || (tx_state == TX_DATA) || (tx_state == TX_STOP);
    assign serial     = tx_driving ? tx_out : 1'bz;

    assign rx_valid       = !rx_empty;
    assign rx_pop         = rx_valid && rx_ready;
    assign tx_ready       = enable && !tx_full;
    assign tx_push        = tx_valid && tx_ready;
    assign rx_overflow    = enable && rx_push_q && rx_full;
    assign rx_frame_error = enable && rx_ferr_q;
    assign busy           = (rx_state != RX_IDLE) || (tx_state != TX_IDLE);

    hd_resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!enable),
        .push  (rx_push_q),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    hd_resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!enable),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    // Two-flop synchroniser on the shared pin; idles high to match the released line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0     <= 1'b1;
            line_s    <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync0     <= serial;
            line_s    <= sync0;
            line_prev <= line_s;
        end
    end

    // RX next state: start-edge hunt, mid-bit sampling, stop check; blind while our own TX drives.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt + 1'b1;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_push_next  = 1'b0;
        rx_ferr_next  = 1'b0;
        if (tx_driving) begin
            rx_state_next = RX_IDLE;
            rx_cnt_next   = '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt_next = '0;
                    if (line_prev && !line_s) rx_state_next = RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt_next   = '0;
                        rx_bit_next   = 3'd0;
                        rx_state_next = line_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CPB_LAST) begin
                        rx_cnt_next   = '0;
                        rx_shift_next = {line_s, rx_shift[7:1]};
                        rx_bit_next   = rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state_next = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CPB_LAST) begin
                        rx_cnt_next   = '0;
                        rx_state_next = RX_IDLE;
                        if (line_s) rx_push_next = 1'b1;
                        else        rx_ferr_next = 1'b1;
                    end
                end
                default: rx_state_next = RX_IDLE;
            endcase
        end
    end

    // RX state register; dropping enable aborts the frame and suppresses pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'h00;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else if (!enable) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'h00;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            rx_cnt    <= rx_cnt_next;
            rx_bit    <= rx_bit_next;
            rx_shift  <= rx_shift_next;
            rx_push_q <= rx_push_next;
            rx_ferr_q <= rx_ferr_next;
        end
    end

    // Pin value for the current TX phase; high whenever not sending a start or data bit.
    always_comb begin
        tx_out = 1'b1;
        case (tx_state)
            TX_START: tx_out = 1'b0;
            TX_DATA:  tx_out = tx_shift[0];
            default:  tx_out = 1'b1;
        endcase
    end

`ifdef HD_RESP_ECHO_CHECK_EN
    // Sample point sits mid-bit plus the synchroniser latency, so line_s shows this bit.
    localparam cnt_t ECHO_AT = cnt_t'(HALF + 2);
    logic collision_q;
    logic collision_next;
    assign collision = enable && collision_q;
`else
    assign collision = 1'b0;
`endif

    // TX next state: guard on idle line, then frame bits LSB first, bursting while bytes remain.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + 1'b1;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_pop        = 1'b0;
`ifdef HD_RESP_ECHO_CHECK_EN
        collision_next = 1'b0;
`endif
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_next = '0;
                if (!tx_empty) tx_state_next = TX_GUARD;
            end
            TX_GUARD: begin
                if (tx_empty) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                end else if (!line_s || (rx_state != RX_IDLE)) begin
                    tx_cnt_next = '0;
                end else if (tx_cnt == GUARD_LAST) begin
                    tx_cnt_next   = '0;
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_head;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == CPB_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = 3'd0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == CPB_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    tx_bit_next   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == CPB_LAST) begin
                    tx_cnt_next = '0;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_head;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
`ifdef HD_RESP_ECHO_CHECK_EN
        if (tx_driving && (tx_cnt == ECHO_AT) && (line_s != tx_out)) begin
            tx_state_next  = TX_GUARD;
            tx_cnt_next    = '0;
            tx_pop         = 1'b0;
            collision_next = 1'b1;
        end
`endif
    end

    // TX state register; dropping enable releases the pin on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else if (!enable) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
        end
    end

`ifdef HD_RESP_ECHO_CHECK_EN
    // One-cycle collision pulse, aligned with the cycle the pin is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          collision_q <= 1'b0;
        else if (!enable) collision_q <= 1'b0;
        else              collision_q <= collision_next;
    end
`endif
endmodule
